ccu_snoop_sequencer: RTL and testbench
======================================

# ccu_snoop_sequencer

Sequences coherency snoops for the culsans multi-core cache-coherent interconnect. It arbitrates round-robin between per-core snoop-triggering requests, broadcasts the granted request on the ACE AC channel to every other core, and collects their CR responses. It then returns one aggregated response to the coherency unit's datapath. It sits between the per-core request decoders and the cores' AC/CR ports; only one snoop transaction is in flight at a time.

## Interface
Parameters:
- NbCores, culsans_pkg::NB_CORES (2): number of cores; legal range 2..4.
- AddrWidth, culsans_pkg::AddrWidth (64): snoop address width.
- IdxWidth, $clog2(NbCores): core index width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  NbCores  per-core snoop request valid.
- req_ready_o  out  NbCores  per-core grant/accept.
- req_addr_i  in  NbCores x AddrWidth  per-core snoop address.
- req_snoop_i  in  NbCores x 4  per-core ace_pkg::acsnoop_t.
- ac_valid_o  out  NbCores  per-core AC valid.
- ac_ready_i  in  NbCores  per-core AC ready.
- ac_addr_o  out  AddrWidth  AC address, shared by all cores.
- ac_snoop_o  out  4  AC snoop type, shared by all cores.
- cr_valid_i  in  NbCores  per-core CR valid.
- cr_ready_o  out  NbCores  per-core CR ready.
- cr_resp_i  in  NbCores x 5  per-core ace_pkg::crresp_t: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- rsp_valid_o  out  1  aggregated response valid.
- rsp_ready_i  in  1  aggregated response ready.
- rsp_initiator_o  out  IdxWidth  core whose request was served.
- rsp_resp_o  out  5  bitwise OR of all collected CR responses.
- rsp_src_o  out  IdxWidth  lowest-index responder with DataTransfer=1; 0 if none.
- busy_o  out  1  high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, SNOOP and RESP.
- IDLE:
  - If any req_valid_i is high, pick a winner round-robin. The search starts at the priority pointer and takes the first valid index in increasing order, wrapping.
  - req_ready_o[winner]=1 combinationally in the same cycle. All other bits are 0.
  - On that handshake, register the winner's addr, snoop type and index.
  - Set ac_pend = all cores except the initiator. Clear cr_done and the response accumulator.
  - Set the pointer to (winner+1) mod NbCores, then go to SNOOP.
- SNOOP:
  - ac_valid_o[i] = ac_pend[i]. On ac_valid_o[i] & ac_ready_i[i], clear ac_pend[i].
  - ac_addr_o and ac_snoop_o are stable for the whole state.
  - cr_ready_o[i] = ~ac_pend[i] & ~cr_done[i] & (i != initiator). This uses the registered ac_pend, so a CR is never accepted in the same cycle as its own AC handshake.
  - On a CR handshake: set cr_done[i], OR cr_resp_i[i] into the accumulator, and set rsp_src if DataTransfer=1 and i is lower than any earlier data source.
  - Handshakes to different cores can occur in the same cycle in any combination.
  - cr_valid_i from the initiator, or from a core still in ac_pend, is ignored and never acknowledged.
  - When ac_pend==0 and cr_done equals all non-initiator cores, go to RESP on the next edge.
- RESP:
  - rsp_valid_o=1. rsp_initiator_o, rsp_resp_o and rsp_src_o are held stable until rsp_ready_i.
  - On the handshake, go to IDLE.
- Req inputs are ignored outside IDLE: req_ready_o=0.
- Reset values: every output is 0, FSM is IDLE, pointer=0, ac_pend=0, cr_done=0, accumulator=0. Reset mid-transaction abandons it; no AC/CR/rsp is issued afterwards for it.

## Timing
- Request handshake at cycle T (in IDLE) puts ac_valid_o high at T+1.
- Minimum path with immediate ready: AC handshake at T+1, CR at T+2, rsp_valid_o at T+3, back in IDLE at T+4 if rsp_ready_i is high at T+3.
- Back-to-back grant interval is 4 cycles minimum.
- No combinational path from ac_ready_i or cr_valid_i to any valid output.
- req_ready_o depends combinationally on req_valid_i.
- rsp_valid_o and all AC fields are driven from registers.
- A stalled responder blocks indefinitely; there is no timeout.

## Test plan
- Single request: NbCores=2. Core0 requests addr 0x8004_0040, snoop 4'b0001. Core1 gives ac_ready and CR 5'b01000 one cycle later. Required: ac_valid_o=2'b10 at T+1, rsp_valid_o at T+3, rsp_resp_o=5'b01000, rsp_initiator_o=0, rsp_src_o=0.
- Round-robin: NbCores=4. All four req_valid_i are held high for four transactions. Required: grant order 0,1,2,3; then the pointer wraps and core0 is granted again.
- Staggered responders: NbCores=4, initiator 2. ac_ready arrives at cycles 1,3,5 for cores 0,1,3. CRs return in order 3,0,1 with resp 5'b00001, 0, 5'b00101. Required: rsp_resp_o=5'b00101, rsp_src_o=0, and rsp_valid_o only after the last CR.
- Early CR ignored: a core raises cr_valid_i before its AC handshake, and the initiator also raises cr_valid_i. Required: cr_ready_o for both stays 0 until the core's AC handshake completes; the initiator is never acknowledged.
- Backpressure: rsp_ready_i is held low for 5 cycles while a new req_valid_i is pending. Required: rsp fields stay stable, req_ready_o=0 throughout, and the grant occurs in the cycle after the rsp handshake.
- Reset mid-SNOOP: rst_ni=0 for one cycle during SNOOP. Required: all outputs are 0 on the next edge, FSM is IDLE, and the next grant goes to core0.

Source files
------------

// File: rtl/ccu_snoop_sequencer.sv
// ccu_snoop_sequencer
// Serialises coherency snoops: grants one per-core request (round-robin),
// broadcasts it on the AC channel to every other core, collects their CR
// responses and returns one aggregated response.
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   req_valid_i/ready_o/addr_i/snoop_i  per-core snoop requests
//   ac_valid_o/ready_i, ac_addr_o/snoop_o   AC broadcast (shared addr/type)
//   cr_valid_i/ready_o/resp_i      per-core CR responses
//   rsp_valid_o/ready_i, rsp_initiator_o/resp_o/src_o   aggregated response
//   busy_o                         transaction in flight
module ccu_snoop_sequencer #(
  parameter int unsigned NbCores   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdxWidth  = $clog2(NbCores)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NbCores-1:0]                req_valid_i,
  output logic [NbCores-1:0]                req_ready_o,
  input  logic [NbCores-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NbCores-1:0][3:0]           req_snoop_i,
  output logic [NbCores-1:0]                ac_valid_o,
  input  logic [NbCores-1:0]                ac_ready_i,
  output logic [AddrWidth-1:0]              ac_addr_o,
  output logic [3:0]                        ac_snoop_o,
  input  logic [NbCores-1:0]                cr_valid_i,
  output logic [NbCores-1:0]                cr_ready_o,
  input  logic [NbCores-1:0][4:0]           cr_resp_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [IdxWidth-1:0]               rsp_initiator_o,
  output logic [4:0]                        rsp_resp_o,
  output logic [IdxWidth-1:0]               rsp_src_o,
  output logic                              busy_o
);

  typedef enum logic [1:0] {StIdle, StSnoop, StResp} state_e;

  state_e                 state_q, state_d;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [IdxWidth-1:0]    init_q, init_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  logic [NbCores-1:0]     ac_pend_q, ac_pend_d;
  logic [NbCores-1:0]     cr_done_q, cr_done_d;
  logic [4:0]             acc_q, acc_d;
  logic [IdxWidth-1:0]    src_q, src_d;
  logic                   src_vld_q, src_vld_d;

  logic                   win_found;
  logic [IdxWidth-1:0]    win_idx;
  logic [NbCores-1:0]     init_mask;

  // Index k steps after p, wrapping at NbCores.
  function automatic logic [IdxWidth-1:0] rr_idx(input logic [IdxWidth-1:0] p, input int k);
    return IdxWidth'((int'(p) + k) % int'(NbCores));
  endfunction

  // All cores except idx.
  function automatic logic [NbCores-1:0] others_mask(input logic [IdxWidth-1:0] idx);
    logic [NbCores-1:0] m;
    for (int i = 0; i < NbCores; i++) m[i] = (IdxWidth'(i) != idx);
    return m;
  endfunction

  // Round-robin search starting at the priority pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NbCores; k++) begin
      if (!win_found && req_valid_i[rr_idx(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    init_mask = others_mask(init_q);
    for (int i = 0; i < NbCores; i++) begin
      // Gated by reset so no request is accepted and then discarded.
      req_ready_o[i] = rst_ni && (state_q == StIdle) && win_found && (win_idx == IdxWidth'(i));
    end
    // Registered ac_pend: a CR is never taken in the cycle of its own AC handshake.
    cr_ready_o = (state_q == StSnoop) ? (~ac_pend_q & ~cr_done_q & init_mask) : '0;
  end

  assign ac_valid_o      = ac_pend_q;
  assign ac_addr_o       = addr_q;
  assign ac_snoop_o      = snoop_q;
  assign rsp_valid_o     = (state_q == StResp);
  assign rsp_initiator_o = init_q;
  assign rsp_resp_o      = acc_q;
  assign rsp_src_o       = src_q;
  assign busy_o          = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    init_d    = init_q;
    addr_d    = addr_q;
    snoop_d   = snoop_q;
    ac_pend_d = ac_pend_q;
    cr_done_d = cr_done_q;
    acc_d     = acc_q;
    src_d     = src_q;
    src_vld_d = src_vld_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          init_d    = win_idx;
          addr_d    = req_addr_i[win_idx];
          snoop_d   = req_snoop_i[win_idx];
          ac_pend_d = others_mask(win_idx);
          cr_done_d = '0;
          acc_d     = '0;
          src_d     = '0;
          src_vld_d = 1'b0;
          ptr_d     = (win_idx == IdxWidth'(NbCores - 1)) ? '0 : win_idx + IdxWidth'(1);
          state_d   = StSnoop;
        end
      end
      StSnoop: begin
        for (int i = 0; i < NbCores; i++) begin
          if (ac_pend_q[i] && ac_ready_i[i]) ac_pend_d[i] = 1'b0;
          if (cr_ready_o[i] && cr_valid_i[i]) begin
            cr_done_d[i] = 1'b1;
            acc_d        = acc_d | cr_resp_i[i];
            // Ascending scan keeps the lowest-index data source.
            if (cr_resp_i[i][0] && (!src_vld_d || IdxWidth'(i) < src_d)) begin
              src_d     = IdxWidth'(i);
              src_vld_d = 1'b1;
            end
          end
        end
        // Look at next-state so the last CR moves us to RESP on the same edge.
        if (ac_pend_d == '0 && cr_done_d == init_mask) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      init_q    <= '0;
      addr_q    <= '0;
      snoop_q   <= '0;
      ac_pend_q <= '0;
      cr_done_q <= '0;
      acc_q     <= '0;
      src_q     <= '0;
      src_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      init_q    <= init_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      ac_pend_q <= ac_pend_d;
      cr_done_q <= cr_done_d;
      acc_q     <= acc_d;
      src_q     <= src_d;
      src_vld_q <= src_vld_d;
    end
  end

endmodule

// File: tb/tb_ccu_snoop_sequencer.sv
// tb_ccu_snoop_sequencer
// Directed bench for ccu_snoop_sequencer: a 2-core instance for the single
// request case and a 4-core instance for arbitration, response collection,
// backpressure and reset. Inputs change 1 time unit after the rising edge,
// outputs are checked 1 unit later.
module tb_ccu_snoop_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 2-core instance
  logic [1:0]        rv2, rr2, acv2, acr2, crv2, crr2;
  logic [1:0][63:0]  ra2;
  logic [1:0][3:0]   rs2;
  logic [1:0][4:0]   crp2;
  logic [63:0]       aca2;
  logic [3:0]        acs2;
  logic              rspv2, rspr2, busy2;
  logic              rini2, rsrc2;
  logic [4:0]        rres2;

  // 4-core instance
  logic [3:0]        rv4, rr4, acv4, acr4, crv4, crr4;
  logic [3:0][63:0]  ra4;
  logic [3:0][3:0]   rs4;
  logic [3:0][4:0]   crp4;
  logic [63:0]       aca4;
  logic [3:0]        acs4;
  logic              rspv4, rspr4, busy4;
  logic [1:0]        rini4, rsrc4;
  logic [4:0]        rres4;

  int vecs = 0;
  int errs = 0;

  ccu_snoop_sequencer #(.NbCores(2), .AddrWidth(64)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv2), .req_ready_o(rr2), .req_addr_i(ra2), .req_snoop_i(rs2),
    .ac_valid_o(acv2), .ac_ready_i(acr2), .ac_addr_o(aca2), .ac_snoop_o(acs2),
    .cr_valid_i(crv2), .cr_ready_o(crr2), .cr_resp_i(crp2),
    .rsp_valid_o(rspv2), .rsp_ready_i(rspr2), .rsp_initiator_o(rini2),
    .rsp_resp_o(rres2), .rsp_src_o(rsrc2), .busy_o(busy2)
  );

  ccu_snoop_sequencer #(.NbCores(4), .AddrWidth(64)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(rv4), .req_ready_o(rr4), .req_addr_i(ra4), .req_snoop_i(rs4),
    .ac_valid_o(acv4), .ac_ready_i(acr4), .ac_addr_o(aca4), .ac_snoop_o(acs4),
    .cr_valid_i(crv4), .cr_ready_o(crr4), .cr_resp_i(crp4),
    .rsp_valid_o(rspv4), .rsp_ready_i(rspr4), .rsp_initiator_o(rini4),
    .rsp_resp_o(rres4), .rsp_src_o(rsrc4), .busy_o(busy4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rv4 = 4'b1111;  // reset must also mask req_ready
    step(); step();
    settle();
    vecs++; if (rr4 !== 4'b0) begin errs++; $display("FAIL reset_req_ready got %b exp 0000", rr4); end
    vecs++; if (acv4 !== 4'b0) begin errs++; $display("FAIL reset_ac_valid got %b exp 0000", acv4); end
    vecs++; if (crr4 !== 4'b0) begin errs++; $display("FAIL reset_cr_ready got %b exp 0000", crr4); end
    vecs++; if ({rspv4, busy4} !== 2'b00) begin
      errs++; $display("FAIL reset_rsp_busy got %b exp 00", {rspv4, busy4});
    end
    vecs++; if ({aca4, acs4, rres4, rini4, rsrc4} !== '0) begin
      errs++; $display("FAIL reset_fields got addr=%h snoop=%h resp=%b exp all 0", aca4, acs4, rres4);
    end
    vecs++; if ({acv2, busy2, rspv2} !== 4'b0) begin
      errs++; $display("FAIL reset_dut2 got %b exp 0000", {acv2, busy2, rspv2});
    end
    rv4 = 4'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    rv2 = 2'b01; ra2[0] = 64'h0000_0000_8004_0040; rs2[0] = 4'b0001;
    settle();
    vecs++; if (rr2 !== 2'b01) begin errs++; $display("FAIL single_grant got %b exp 01", rr2); end
    step();  // T+1
    rv2 = 2'b00;
    vecs++; if (acv2 !== 2'b10) begin errs++; $display("FAIL single_ac_valid got %b exp 10", acv2); end
    vecs++; if (aca2 !== 64'h0000_0000_8004_0040 || acs2 !== 4'b0001) begin
      errs++; $display("FAIL single_ac_fields got %h/%b exp 80040040/0001", aca2, acs2);
    end
    vecs++; if (crr2 !== 2'b00) begin errs++; $display("FAIL single_cr_early got %b exp 00", crr2); end
    acr2 = 2'b10;
    step();  // T+2
    acr2 = 2'b00;
    vecs++; if (acv2 !== 2'b00 || crr2 !== 2'b10) begin
      errs++; $display("FAIL single_cr_ready got ac=%b cr=%b exp 00/10", acv2, crr2);
    end
    crv2 = 2'b10; crp2[1] = 5'b01000;
    step();  // T+3
    crv2 = 2'b00;
    vecs++; if (rspv2 !== 1'b1) begin errs++; $display("FAIL single_rsp_valid got %b exp 1", rspv2); end
    vecs++; if (rres2 !== 5'b01000 || rini2 !== 1'b0 || rsrc2 !== 1'b0) begin
      errs++; $display("FAIL single_rsp_fields got %b/%b/%b exp 01000/0/0", rres2, rini2, rsrc2);
    end
    rspr2 = 1'b1;
    step();  // T+4
    rspr2 = 1'b0;
    vecs++; if (rspv2 !== 1'b0 || busy2 !== 1'b0) begin
      errs++; $display("FAIL single_idle got rsp=%b busy=%b exp 0/0", rspv2, busy2);
    end
  endtask

  task automatic test_round_robin();
    int ng;
    int last;
    int exp_order[5];
    logic [3:0] exp_gnt;
    exp_order = '{0, 1, 2, 3, 0};
    rv4 = 4'b1111; acr4 = 4'b1111; crv4 = 4'b1111; crp4 = '0; rspr4 = 1'b1;
    settle();
    ng = 0; last = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      if (rr4 != 4'b0) begin
        exp_gnt = 4'b0001 << exp_order[ng];
        vecs++; if (rr4 !== exp_gnt) begin
          errs++; $display("FAIL rr_grant%0d got %b exp %b", ng, rr4, exp_gnt);
        end
        if (ng > 0) begin
          vecs++; if (c - last !== 4) begin
            errs++; $display("FAIL rr_interval%0d got %0d exp 4", ng, c - last);
          end
        end
        last = c;
        ng++;
      end
      step();
    end
    vecs++; if (ng !== 5) begin errs++; $display("FAIL rr_count got %0d exp 5", ng); end
    rv4 = 4'b0;
    for (int c = 0; c < 20 && busy4 === 1'b1; c++) step();
    vecs++; if (busy4 !== 1'b0) begin errs++; $display("FAIL rr_drain got busy=%b exp 0", busy4); end
    acr4 = 4'b0; crv4 = 4'b0; rspr4 = 1'b0;
  endtask

  task automatic test_staggered();
    rv4 = 4'b0100; ra4[2] = 64'h0000_0000_8004_1000; rs4[2] = 4'b1011;
    settle();
    vecs++; if (rr4 !== 4'b0100) begin errs++; $display("FAIL stag_grant got %b exp 0100", rr4); end
    step();  // 1
    rv4 = 4'b0;
    vecs++; if (acv4 !== 4'b1011 || aca4 !== 64'h0000_0000_8004_1000 || acs4 !== 4'b1011) begin
      errs++; $display("FAIL stag_ac got %b/%h/%b exp 1011/80041000/1011", acv4, aca4, acs4);
    end
    acr4 = 4'b0001;
    step();  // 2
    acr4 = 4'b0;
    vecs++; if (acv4 !== 4'b1010 || crr4 !== 4'b0001) begin
      errs++; $display("FAIL stag_c2 got ac=%b cr=%b exp 1010/0001", acv4, crr4);
    end
    step();  // 3
    acr4 = 4'b0010;
    step();  // 4
    acr4 = 4'b0;
    vecs++; if (acv4 !== 4'b1000) begin errs++; $display("FAIL stag_c4 got %b exp 1000", acv4); end
    step();  // 5
    acr4 = 4'b1000;
    step();  // 6
    acr4 = 4'b0;
    vecs++; if (acv4 !== 4'b0000 || crr4 !== 4'b1011) begin
      errs++; $display("FAIL stag_c6 got ac=%b cr=%b exp 0000/1011", acv4, crr4);
    end
    crv4 = 4'b1000; crp4[3] = 5'b00101;
    step();  // 7
    vecs++; if (crr4 !== 4'b0011 || rspv4 !== 1'b0) begin
      errs++; $display("FAIL stag_c7 got cr=%b rsp=%b exp 0011/0", crr4, rspv4);
    end
    crv4 = 4'b0001; crp4[0] = 5'b00001;
    step();  // 8
    vecs++; if (crr4 !== 4'b0010 || rspv4 !== 1'b0) begin
      errs++; $display("FAIL stag_c8 got cr=%b rsp=%b exp 0010/0", crr4, rspv4);
    end
    crv4 = 4'b0010; crp4[1] = 5'b00000;
    step();  // 9
    crv4 = 4'b0;
    vecs++; if (rspv4 !== 1'b1 || rres4 !== 5'b00101 || rsrc4 !== 2'd0 || rini4 !== 2'd2) begin
      errs++; $display("FAIL stag_rsp got v=%b resp=%b src=%0d init=%0d exp 1/00101/0/2",
                       rspv4, rres4, rsrc4, rini4);
    end
    rspr4 = 1'b1;
    step();  // 10
    rspr4 = 1'b0;
    vecs++; if (busy4 !== 1'b0 || rspv4 !== 1'b0) begin
      errs++; $display("FAIL stag_idle got busy=%b rsp=%b exp 0/0", busy4, rspv4);
    end
  endtask

  task automatic test_early_cr();
    rv4 = 4'b1000;
    settle();
    vecs++; if (rr4 !== 4'b1000) begin errs++; $display("FAIL early_grant got %b exp 1000", rr4); end
    step();  // 1
    rv4 = 4'b0;
    crv4 = 4'b1111;
    crp4[0] = 5'b10000; crp4[1] = 5'b00010; crp4[2] = 5'b00000; crp4[3] = 5'b11111;
    acr4 = 4'b0110;
    settle();
    vecs++; if (acv4 !== 4'b0111 || crr4 !== 4'b0000) begin
      errs++; $display("FAIL early_c1 got ac=%b cr=%b exp 0111/0000", acv4, crr4);
    end
    step();  // 2
    acr4 = 4'b0;
    vecs++; if (acv4 !== 4'b0001 || crr4 !== 4'b0110) begin
      errs++; $display("FAIL early_c2 got ac=%b cr=%b exp 0001/0110", acv4, crr4);
    end
    step();  // 3
    vecs++; if (crr4 !== 4'b0000) begin errs++; $display("FAIL early_c3 got %b exp 0000", crr4); end
    acr4 = 4'b0001;
    step();  // 4
    acr4 = 4'b0;
    vecs++; if (crr4 !== 4'b0001) begin errs++; $display("FAIL early_c4 got %b exp 0001", crr4); end
    step();  // 5
    crv4 = 4'b1000;  // initiator keeps asserting
    settle();
    vecs++; if (rspv4 !== 1'b1 || crr4 !== 4'b0000) begin
      errs++; $display("FAIL early_c5 got rsp=%b cr=%b exp 1/0000", rspv4, crr4);
    end
    vecs++; if (rres4 !== 5'b10010 || rini4 !== 2'd3 || rsrc4 !== 2'd0) begin
      errs++; $display("FAIL early_rsp got %b/%0d/%0d exp 10010/3/0", rres4, rini4, rsrc4);
    end
  endtask

  task automatic test_backpressure();
    rv4 = 4'b0010; rspr4 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      vecs++; if (rspv4 !== 1'b1 || rres4 !== 5'b10010 || rini4 !== 2'd3 || rsrc4 !== 2'd0) begin
        errs++; $display("FAIL bp_hold%0d got %b/%b/%0d/%0d exp 1/10010/3/0",
                         c, rspv4, rres4, rini4, rsrc4);
      end
      vecs++; if (rr4 !== 4'b0) begin errs++; $display("FAIL bp_req%0d got %b exp 0000", c, rr4); end
      step();
    end
    crv4 = 4'b0;
    rspr4 = 1'b1;
    settle();
    vecs++; if (rr4 !== 4'b0) begin errs++; $display("FAIL bp_hs_req got %b exp 0000", rr4); end
    step();
    rspr4 = 1'b0;
    settle();
    vecs++; if (rspv4 !== 1'b0 || rr4 !== 4'b0010) begin
      errs++; $display("FAIL bp_grant got rsp=%b req=%b exp 0/0010", rspv4, rr4);
    end
    step();
    rv4 = 4'b0;
    vecs++; if (busy4 !== 1'b1 || acv4 !== 4'b1101) begin
      errs++; $display("FAIL bp_snoop got busy=%b ac=%b exp 1/1101", busy4, acv4);
    end
  endtask

  task automatic test_reset_mid_snoop();
    rst_n = 1'b0;
    step();
    vecs++; if ({acv4, crr4, rr4, rspv4, busy4} !== '0 || {aca4, acs4, rres4, rini4, rsrc4} !== '0) begin
      errs++; $display("FAIL mid_reset got ac=%b cr=%b req=%b rsp=%b busy=%b exp all 0",
                       acv4, crr4, rr4, rspv4, busy4);
    end
    rst_n = 1'b1;
    acr4 = 4'b1111; crv4 = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      vecs++; if ({acv4, crr4, rspv4, busy4} !== '0) begin
        errs++; $display("FAIL mid_after%0d got ac=%b cr=%b rsp=%b busy=%b exp 0",
                         c, acv4, crr4, rspv4, busy4);
      end
    end
    acr4 = 4'b0; crv4 = 4'b0;
    rv4 = 4'b1111;
    settle();
    vecs++; if (rr4 !== 4'b0001) begin errs++; $display("FAIL mid_next_grant got %b exp 0001", rr4); end
    rv4 = 4'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rv2 = '0; ra2 = '0; rs2 = '0; acr2 = '0; crv2 = '0; crp2 = '0; rspr2 = 1'b0;
    rv4 = '0; ra4 = '0; rs4 = '0; acr4 = '0; crv4 = '0; crp4 = '0; rspr4 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_staggered();
    test_early_cr();
    test_backpressure();
    test_reset_mid_snoop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
